// File: rtl/sram_emu.sv
// sram_emu: on-chip responder for an asynchronous SRAM port, backed by a word array.
// Define SRAM_EMU_CLEAR_EN for a post-reset zero sweep of the array, reported on busy.
module sram_emu #(
    parameter int AW     = 12,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk_sys,
    input  logic             rst_,
    input  logic             ce_,
    input  logic             oe_,
    input  logic             we_,
    input  logic             ub_,
    input  logic             lb_,
    input  logic [17:0]      a,
    input  logic [15:0]      d_in,
    output logic [15:0]      d_out,
    output logic             d_oe,
    output logic             err_cont,
    output logic             err_range,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic             busy
);
    // state    | meaning
    // IDLE     | waiting for a strobe
    // RD_WAIT  | read latency countdown
    // RD_DRIVE | driving read data while ce&oe
    // WR_HOLD  | tracking write data until we/ce release
    // ERR      | oe/we contention, waiting for all strobes idle
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_HOLD, ERR} state_t;

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    logic [4:0]  str_s1;
    logic [4:0]  str_s2;
    logic [17:0] a_s1;
    logic [17:0] a_s2;
    logic [15:0] d_s1;
    logic [15:0] d_s2;

    // strobe vector order: {ce_, oe_, we_, ub_, lb_}
    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            str_s1 <= '1;
            str_s2 <= '1;
            a_s1   <= '0;
            a_s2   <= '0;
            d_s1   <= '0;
            d_s2   <= '0;
        end else begin
            str_s1 <= {ce_, oe_, we_, ub_, lb_};
            str_s2 <= str_s1;
            a_s1   <= a;
            a_s2   <= a_s1;
            d_s1   <= d_in;
            d_s2   <= d_s1;
        end
    end

    logic ce;
    logic oe;
    logic we;
    logic ub;
    logic lb;
    assign ce = !str_s2[4];
    assign oe = !str_s2[3];
    assign we = !str_s2[2];
    assign ub = !str_s2[1];
    assign lb = !str_s2[0];

    logic [15:0] mem [2**AW];

    state_t      state;
    logic [2:0]  lat_cnt;
    logic [17:0] addr_q;
    logic [17:0] hold_a;
    logic [15:0] hold_d;
    logic        hold_ub;
    logic        hold_lb;
    logic        drive_q;

    logic        a_in_range;
    logic        addr_in_range;
    logic        hold_in_range;
    logic [15:0] rd_now;
    logic [15:0] rd_q;
    logic        wr_release;

    always_comb begin
        a_in_range    = (a_s2[17:AW] == '0);
        addr_in_range = (addr_q[17:AW] == '0);
        hold_in_range = (hold_a[17:AW] == '0);
        rd_now        = a_in_range ? mem[a_s2[AW-1:0]] : 16'hFFFF;
        rd_q          = addr_in_range ? mem[addr_q[AW-1:0]] : 16'hFFFF;
        wr_release    = (state == WR_HOLD) && !(ce && oe) && !(ce && we);
    end

    // d_oe drops combinationally with the synced strobe so release is seen in the same cycle
    assign d_oe = drive_q && ce && oe && !we;

`ifdef SRAM_EMU_CLEAR_EN
    logic          clr_active;
    logic [AW-1:0] clr_addr;

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            clr_active <= 1'b1;
            clr_addr   <= '0;
        end else if (clr_active) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1) begin
                clr_active <= 1'b0;
            end
        end
    end

    assign busy = clr_active;
`else
    assign busy = 1'b0;
`endif

    logic          mem_we_hi;
    logic          mem_we_lo;
    logic [AW-1:0] mem_wa;
    logic [15:0]   mem_wd;

    always_comb begin
        mem_we_hi = 1'b0;
        mem_we_lo = 1'b0;
        mem_wa    = hold_a[AW-1:0];
        mem_wd    = hold_d;
`ifdef SRAM_EMU_CLEAR_EN
        if (clr_active) begin
            mem_we_hi = 1'b1;
            mem_we_lo = 1'b1;
            mem_wa    = clr_addr;
            mem_wd    = '0;
        end else
`endif
        if (wr_release && hold_in_range) begin
            mem_we_hi = hold_ub;
            mem_we_lo = hold_lb;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (mem_we_hi) mem[mem_wa][15:8] <= mem_wd[15:8];
        if (mem_we_lo) mem[mem_wa][7:0]  <= mem_wd[7:0];
    end

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            addr_q    <= '0;
            hold_a    <= '0;
            hold_d    <= '0;
            hold_ub   <= 1'b0;
            hold_lb   <= 1'b0;
            drive_q   <= 1'b0;
            d_out     <= '0;
            err_cont  <= 1'b0;
            err_range <= 1'b0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!busy) begin
                        if (ce && oe && we) begin
                            err_cont <= 1'b1;
                            state    <= ERR;
                        end else if (ce && oe) begin
                            addr_q <= a_s2;
                            if (!a_in_range) err_range <= 1'b1;
                            if (RD_LAT == 0) begin
                                d_out   <= rd_now;
                                drive_q <= 1'b1;
                                rd_cnt  <= rd_cnt + 1'b1;
                                state   <= RD_DRIVE;
                            end else begin
                                lat_cnt <= RD_LAT_C;
                                state   <= RD_WAIT;
                            end
                        end else if (ce && we) begin
                            hold_a  <= a_s2;
                            hold_d  <= d_s2;
                            hold_ub <= ub;
                            hold_lb <= lb;
                            if (!a_in_range) err_range <= 1'b1;
                            state   <= WR_HOLD;
                        end
                    end
                end
                RD_WAIT: begin
                    if (ce && oe && we) begin
                        err_cont <= 1'b1;
                        state    <= ERR;
                    end else if (!(ce && oe)) begin
                        state <= IDLE;
                    end else begin
                        // the IDLE exit cycle is the first latency cycle, so terminal count is hit at 1->0
                        lat_cnt <= lat_cnt - 3'd1;
                        if (lat_cnt == 3'd1) begin
                            d_out   <= rd_q;
                            drive_q <= 1'b1;
                            rd_cnt  <= rd_cnt + 1'b1;
                            state   <= RD_DRIVE;
                        end
                    end
                end
                RD_DRIVE: begin
                    if (ce && oe && we) begin
                        drive_q  <= 1'b0;
                        err_cont <= 1'b1;
                        state    <= ERR;
                    end else if (!(ce && oe)) begin
                        drive_q <= 1'b0;
                        state   <= IDLE;
                    end else if (a_s2 != addr_q) begin
                        addr_q <= a_s2;
                        d_out  <= rd_now;
                        if (!a_in_range) err_range <= 1'b1;
                    end
                end
                WR_HOLD: begin
                    if (ce && oe) begin
                        err_cont <= 1'b1;
                        state    <= ERR;
                    end else if (ce && we) begin
                        hold_a  <= a_s2;
                        hold_d  <= d_s2;
                        hold_ub <= ub;
                        hold_lb <= lb;
                    end else begin
                        if (hold_in_range) wr_cnt <= wr_cnt + 1'b1;
                        else               err_range <= 1'b1;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    drive_q <= 1'b0;
                    if (!ce && !oe && !we) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_emu.sv
// Directed bench for sram_emu: vector table of writes/reads plus hand-built corner sequences.
module tb_sram_emu;
    logic        clk_sys;
    logic        rst_;
    logic        ce_;
    logic        oe_;
    logic        we_;
    logic        ub_;
    logic        lb_;
    logic [17:0] a;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        d_oe;
    logic        err_cont;
    logic        err_range;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sram_emu dut (
        .clk_sys   (clk_sys),
        .rst_      (rst_),
        .ce_       (ce_),
        .oe_       (oe_),
        .we_       (we_),
        .ub_       (ub_),
        .lb_       (lb_),
        .a         (a),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .err_cont  (err_cont),
        .err_range (err_range),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .busy      (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          is_wr;
        logic [17:0] addr;
        logic [15:0] data;
        logic        ub_n;
        logic        lb_n;
        logic [15:0] exp_d;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_reset();
        rst_ = 1'b0;
        ce_ = 1'b1; oe_ = 1'b1; we_ = 1'b1; ub_ = 1'b1; lb_ = 1'b1;
        step();
        step();
        rst_ = 1'b1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (busy && n < 6000);
    endtask

    task automatic write_word(input logic [17:0] ad, input logic [15:0] dt,
                              input logic ubn, input logic lbn);
        a = ad; d_in = dt; ub_ = ubn; lb_ = lbn;
        ce_ = 1'b0; we_ = 1'b0;
        repeat (4) step();
        ce_ = 1'b1; we_ = 1'b1;
        repeat (5) step();
    endtask

    task automatic read_word(input logic [17:0] ad, output logic [15:0] dt, output int lat,
                             output logic oe1, output logic oe2);
        a = ad; ub_ = 1'b0; lb_ = 1'b0;
        ce_ = 1'b0; oe_ = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!d_oe && lat < 20);
        dt = d_out;
        ce_ = 1'b1; oe_ = 1'b1;
        step(); oe1 = d_oe;
        step(); oe2 = d_oe;
        repeat (4) step();
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        int          n;
        logic        oe1;
        logic        oe2;
        logic        seen;

        vecs[0]  = '{1'b1, 18'h00005, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 0, 1};
        vecs[1]  = '{1'b0, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1, 1};
        vecs[2]  = '{1'b1, 18'h00007, 16'h1234, 1'b0, 1'b0, 16'h0000, 1, 2};
        vecs[3]  = '{1'b1, 18'h00007, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1, 3};
        vecs[4]  = '{1'b0, 18'h00007, 16'h0000, 1'b0, 1'b0, 16'hAB34, 2, 3};
        vecs[5]  = '{1'b1, 18'h00007, 16'h5555, 1'b1, 1'b1, 16'h0000, 2, 4};
        vecs[6]  = '{1'b0, 18'h00007, 16'h0000, 1'b0, 1'b0, 16'hAB34, 3, 4};
        vecs[7]  = '{1'b1, 18'h00007, 16'h99C3, 1'b1, 1'b0, 16'h0000, 3, 5};
        vecs[8]  = '{1'b0, 18'h00007, 16'h0000, 1'b0, 1'b0, 16'hABC3, 4, 5};
        vecs[9]  = '{1'b1, 18'h00000, 16'h1111, 1'b0, 1'b0, 16'h0000, 4, 6};
        vecs[10] = '{1'b1, 18'h00FFF, 16'h0F0F, 1'b0, 1'b0, 16'h0000, 4, 7};
        vecs[11] = '{1'b0, 18'h00FFF, 16'h0000, 1'b0, 1'b0, 16'h0F0F, 5, 7};
        vecs[12] = '{1'b0, 18'h00000, 16'h0000, 1'b0, 1'b0, 16'h1111, 6, 7};
        vecs[13] = '{1'b0, 18'h00005, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 7, 7};

        a = '0; d_in = '0;
        pulse_reset();
        chk("rst_d_out", 32'(d_out), 32'h0);
        chk("rst_d_oe", 32'(d_oe), 32'h0);
        chk("rst_err_cont", 32'(err_cont), 32'h0);
        chk("rst_err_range", 32'(err_range), 32'h0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'h0);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'h0);
`ifdef SRAM_EMU_CLEAR_EN
        chk("rst_busy", 32'(busy), 32'h1);
        wait_ready(n);
        chk("sweep_cycles", 32'(n), 32'd4096);
        read_word(18'h00000, rd, lat, oe1, oe2);
        chk("clear_word0", 32'(rd), 32'h0);
        read_word(18'h00FFF, rd, lat, oe1, oe2);
        chk("clear_word4095", 32'(rd), 32'h0);
        pulse_reset();
        repeat (1000) step();
        chk("busy_mid_sweep", 32'(busy), 32'h1);
        pulse_reset();
        wait_ready(n);
        chk("sweep_restart_cycles", 32'(n), 32'd4096);
`else
        chk("rst_busy", 32'(busy), 32'h0);
        wait_ready(n);
`endif

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                write_word(vecs[i].addr, vecs[i].data, vecs[i].ub_n, vecs[i].lb_n);
                chk($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
            end else begin
                read_word(vecs[i].addr, rd, lat, oe1, oe2);
                chk($sformatf("v%0d_data", i), 32'(rd), 32'(vecs[i].exp_d));
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
                chk($sformatf("v%0d_rd_cnt", i), 32'(rd_cnt), 32'(vecs[i].exp_rd));
                chk($sformatf("v%0d_oe_hold", i), 32'(oe1), 32'h1);
                chk($sformatf("v%0d_oe_release", i), 32'(oe2), 32'h0);
            end
        end

        // address change while driving: new data, no extra count
        a = 18'h00005; ce_ = 1'b0; oe_ = 1'b0;
        n = 0;
        do begin step(); n++; end while (!d_oe && n < 20);
        chk("reread_first", 32'(d_out), 32'hBEEF);
        a = 18'h00007;
        repeat (4) step();
        chk("reread_data", 32'(d_out), 32'hABC3);
        chk("reread_d_oe", 32'(d_oe), 32'h1);
        chk("reread_rd_cnt", 32'(rd_cnt), 32'd8);
        ce_ = 1'b1; oe_ = 1'b1;
        repeat (6) step();

        // read strobe shorter than the latency is discarded
        a = 18'h00005; ce_ = 1'b0; oe_ = 1'b0;
        seen = 1'b0;
        step(); if (d_oe) seen = 1'b1;
        step(); if (d_oe) seen = 1'b1;
        ce_ = 1'b1; oe_ = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (d_oe) seen = 1'b1;
        end
        chk("abort_no_d_oe", 32'(seen), 32'h0);
        chk("abort_rd_cnt", 32'(rd_cnt), 32'd8);

        // out-of-range accesses
        chk("range_before", 32'(err_range), 32'h0);
        read_word(18'h01000, rd, lat, oe1, oe2);
        chk("range_read_data", 32'(rd), 32'hFFFF);
        chk("range_err", 32'(err_range), 32'h1);
        write_word(18'h01000, 16'hDEAD, 1'b0, 1'b0);
        chk("range_wr_cnt", 32'(wr_cnt), 32'd7);
        read_word(18'h00000, rd, lat, oe1, oe2);
        chk("range_alias_a0", 32'(rd), 32'h1111);

        // contention: oe and we together
        write_word(18'h00009, 16'h4321, 1'b0, 1'b0);
        chk("cont_pre_wr_cnt", 32'(wr_cnt), 32'd8);
        chk("cont_before", 32'(err_cont), 32'h0);
        a = 18'h00009; d_in = 16'hFFFF; ub_ = 1'b0; lb_ = 1'b0;
        ce_ = 1'b0; oe_ = 1'b0; we_ = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (d_oe) seen = 1'b1;
        end
        chk("cont_err", 32'(err_cont), 32'h1);
        chk("cont_no_d_oe", 32'(seen), 32'h0);
        ce_ = 1'b1; oe_ = 1'b1; we_ = 1'b1;
        repeat (5) step();
        chk("cont_sticky", 32'(err_cont), 32'h1);
        chk("cont_wr_cnt", 32'(wr_cnt), 32'd8);
        read_word(18'h00009, rd, lat, oe1, oe2);
        chk("cont_mem_kept", 32'(rd), 32'h4321);

        // reset in the middle of a write aborts it and clears sticky state
        a = 18'h00005; d_in = 16'h0000; ub_ = 1'b0; lb_ = 1'b0;
        ce_ = 1'b0; we_ = 1'b0;
        repeat (4) step();
        rst_ = 1'b0;
        ce_ = 1'b1; we_ = 1'b1;
        step();
        chk("rst2_err_cont", 32'(err_cont), 32'h0);
        chk("rst2_err_range", 32'(err_range), 32'h0);
        chk("rst2_rd_cnt", 32'(rd_cnt), 32'h0);
        chk("rst2_wr_cnt", 32'(wr_cnt), 32'h0);
        step();
        rst_ = 1'b1;
        wait_ready(n);
        read_word(18'h00005, rd, lat, oe1, oe2);
`ifdef SRAM_EMU_CLEAR_EN
        chk("rst2_mem_a5", 32'(rd), 32'h0000);
`else
        chk("rst2_mem_a5", 32'(rd), 32'hBEEF);
`endif
        chk("rst2_wr_after", 32'(wr_cnt), 32'h0);
        chk("rst2_rd_after", 32'(rd_cnt), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_emu.md
Name: sram_emu

Overview:
- Synthesizable on-chip responder for the external asynchronous SRAM interface (CE_/OE_/WE_/UB_/LB_, 18-bit A, 16-bit D) driven by the MERA-400f memory path.
- Stands in for the physical SRAM on boards without one, and serves as a cycle-accurate bench target.
- Backed by an internal word array; all strobes are active-low and are sampled asynchronously.
- Reports contention and address-range errors, and counts committed accesses.

Parameters:
- AW, 12, implemented address bits; depth = 2**AW words; A[17:AW] must be zero.
- RD_LAT, 2, extra clk_sys cycles from a detected read strobe to d_oe/d_out valid (range 0..7).
- CNT_W, 16, width of the access counters.

Ports:
- clk_sys  in  1  system clock.
- rst_  in  1  asynchronous active-low reset.
- ce_  in  1  chip enable, active low.
- oe_  in  1  output enable, active low.
- we_  in  1  write enable, active low.
- ub_  in  1  upper byte lane D[15:8] enable, active low.
- lb_  in  1  lower byte lane D[7:0] enable, active low.
- a  in  18  word address.
- d_in  in  16  data from controller.
- d_out  out  16  read data toward bus.
- d_oe  out  1  drive enable for d_out (top level forms the tristate).
- err_cont  out  1  sticky: OE_ and WE_ both active with CE_ active.
- err_range  out  1  sticky: access with A[17:AW] nonzero.
- rd_cnt  out  CNT_W  committed reads, wraps.
- wr_cnt  out  CNT_W  committed writes, wraps.
- busy  out  1  responder not accepting accesses.

Behaviour:
- Input sync: ce_, oe_, we_, ub_, lb_, a, d_in pass through two flop stages (s1, s2); all decisions use s2. Reset value of every stage is strobes=1, bus=0.
- Controller contract: a/d_in stable from strobe assertion until ≥3 clk_sys after strobe release.
- Reset outputs: d_out=0, d_oe=0, err_cont=0, err_range=0, rd_cnt=0, wr_cnt=0, busy=0 (or 1; see Optional Feature). FSM=IDLE. Reset mid-access aborts it; no commit occurs.
- FSM states: IDLE, RD_WAIT, RD_DRIVE, WR_HOLD, ERR.
- IDLE:
  - ce&oe&!we (s2, active) -> RD_WAIT; latch address; load the latency counter with RD_LAT.
  - ce&we -> WR_HOLD.
  - ce&oe&we -> ERR.
- RD_WAIT:
  - Counter decrements each cycle; at 0, d_out <= mem[a], d_oe=1 -> RD_DRIVE.
  - rd_cnt increments on this entry.
  - Total latency from s2 strobe asserted to d_oe=1 is RD_LAT+1 cycles.
  - If oe or ce drops before that, the read is discarded -> IDLE with no count.
- RD_DRIVE:
  - Holds d_oe=1 while ce&oe.
  - Address change while driving -> re-read next cycle; rd_cnt unchanged.
  - On release, d_oe=0 in the same cycle the s2 strobe goes inactive -> IDLE.
- WR_HOLD:
  - Each cycle captures address, d_in, ub, lb into hold registers.
  - When we or ce releases (s2), commit the hold registers to memory: upper byte only if ub, lower byte only if lb.
  - ub=lb=inactive -> no memory change, but wr_cnt still increments.
  - Returns to IDLE the cycle after the commit.
  - oe asserted during WR_HOLD -> ERR with no commit.
- ERR:
  - Sets err_cont; d_oe=0; no memory change.
  - Returns to IDLE when ce, oe and we are all inactive.
- Range: an out-of-range address sets err_range. A read returns 16'hFFFF; a write is dropped and not counted.
- Counters wrap 2**CNT_W-1 -> 0.
- Sticky errors clear only on reset.
- busy=1 blocks the IDLE exits (strobes ignored) but never interrupts a state already left.

Optional Feature:
- Macro SRAM_EMU_CLEAR_EN.
- Defined:
  - After reset release, busy=1 and a sweep writes 0 to every word, one word per clk_sys (2**AW cycles).
  - busy=0 on the cycle after the last word is written.
  - Accesses during the sweep are ignored and not counted.
  - Reset during the sweep restarts it at word 0.
- Undefined:
  - busy is tied 0; memory content after reset is undefined (bench: X or initial file).

Test Plan:
- Write/read: we_ low, a=18'h00005, d_in=16'hBEEF, both lanes; release, then oe_ low -> d_oe=1 exactly RD_LAT+3 cycles after oe_ falls at input; d_out=16'hBEEF; wr_cnt=1, rd_cnt=1.
- Byte lanes: preload 16'h1234 at a=7; write 16'hABCD with ub_=0, lb_=1 -> read gives 16'hAB34; then ub_=lb_=1 write -> data unchanged, wr_cnt incremented.
- Aborted read: oe_ pulse shorter than RD_LAT+1 synced cycles -> d_oe never asserts; rd_cnt unchanged.
- Contention: ce_=0, oe_=0, we_=0 together -> err_cont=1, d_oe=0, memory at a unchanged; stays 1 after all strobes release; cleared by rst_ low.
- Range: AW=12, a=18'h01000 read -> d_out=16'hFFFF, err_range=1; write to same address -> no count, no change at a=0.
- Clear (SRAM_EMU_CLEAR_EN): after reset, busy=1 for 4096 cycles, then reads at a=0 and a=4095 return 0; rst_ asserted mid-sweep -> sweep restarts and busy lasts a full 4096 cycles.
